// File: rtl/bcd_pkg.sv
// Shared constants for the BCD to Excess-3 conversion stage.
// Excess-3 offset, invalid marker and the largest legal BCD digit.
package bcd_pkg;
  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_INVALID = 4'b0000;
  localparam logic [3:0] BCD_MAX     = 4'd9;
endpackage

// File: rtl/bcd_digit_xs3.sv
// Single-digit combinational BCD to Excess-3 converter.
// Non-BCD input yields the 0000 marker, never a legal Excess-3 code.
module bcd_digit_xs3
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [3:0] xs3,
  output logic       bad
);

  always_comb begin
    bad = (bcd > BCD_MAX);
    xs3 = bad ? XS3_INVALID : bcd + XS3_OFFSET;
  end

endmodule

// File: rtl/bcd2_excess3.sv
// Registered multi-digit BCD to Excess-3 converter stage.
// One-cycle latency; outputs hold their last word while in_vld is low.
module bcd2_excess3
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [4*DIGITS-1:0]   dat_in,
  output logic                  out_vld,
  output logic [4*DIGITS-1:0]   dat_out,
  output logic                  err
);

  logic [4*DIGITS-1:0] xs3;
  logic [DIGITS-1:0]   bad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_xs3 u_dig (
      .bcd (dat_in[4*g +: 4]),
      .xs3 (xs3[4*g +: 4]),
      .bad (bad[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      dat_out <= '0;
      err     <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        dat_out <= xs3;
        err     <= |bad;
      end
    end
  end

endmodule

// File: tb/tb_bcd2_excess3.sv
// Self-checking bench for bcd2_excess3 with DIGITS=1 and DIGITS=4.
// Expected words come from a digit-arithmetic reference model.
module tb_bcd2_excess3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v1;
  logic [3:0]  d1;
  logic        o1;
  logic [3:0]  q1;
  logic        e1;

  logic        v4;
  logic [15:0] d4;
  logic        o4;
  logic [15:0] q4;
  logic        e4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd2_excess3 #(.DIGITS(1)) u1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (v1),
    .dat_in  (d1),
    .out_vld (o1),
    .dat_out (q1),
    .err     (e1)
  );

  bcd2_excess3 #(.DIGITS(4)) u4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (v4),
    .dat_in  (d4),
    .out_vld (o4),
    .dat_out (q4),
    .err     (e4)
  );

  // Reference: each decimal digit d becomes d+3, anything >9 becomes 0.
  function automatic logic [16:0] ref_conv(input logic [15:0] d,
                                           input int n);
    int unsigned v;
    logic [15:0] r;
    logic        bad;
    r = '0;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = (int'(d) >> (4 * i)) % 16;
      if (v <= 9) r = r | 16'((v + 3) << (4 * i));
      else bad = 1'b1;
    end
    return {bad, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v1 = 1'b1;
    v4 = 1'b1;
    d1 = 4'($urandom);
    d4 = 16'($urandom);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({o1, e1, q1} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_d1: got %b exp 000000", {o1, e1, q1});
      end
      n_cmp++;
      if ({o4, e4, q4} !== 18'b0) begin
        n_bad++;
        $display("FAIL reset_d4: got %h exp 0", {o4, e4, q4});
      end
      d1 = 4'($urandom);
      d4 = 16'($urandom);
      tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({o1, o4} !== 2'b00) begin
        n_bad++;
        $display("FAIL post_reset_vld: got %b exp 00", {o1, o4});
      end
    end
  endtask

  task automatic test_sweep;
    logic [5:0] exp;
    for (int k = 0; k <= 10; k++) begin
      v1 = 1'b1;
      d1 = 4'(k % 10);
      tick();
      exp = {1'b1, 1'b0, 4'((k % 10) + 3)};
      n_cmp++;
      if ({o1, e1, q1} !== exp) begin
        n_bad++;
        $display("FAIL sweep_%0d: got %b exp %b", k, {o1, e1, q1}, exp);
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_invalid;
    logic [3:0] vals [2];
    vals[0] = 4'b1010;
    vals[1] = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      v1 = 1'b1;
      d1 = vals[k];
      tick();
      n_cmp++;
      if ({o1, e1, q1} !== 6'b110000) begin
        n_bad++;
        $display("FAIL invalid_%h: got %b exp 110000", vals[k], {o1, e1, q1});
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_gaps;
    v1 = 1'b1;
    d1 = 4'd4;
    tick();
    n_cmp++;
    if ({o1, e1, q1} !== 6'b100111) begin
      n_bad++;
      $display("FAIL gap_first: got %b exp 100111", {o1, e1, q1});
    end
    v1 = 1'b0;
    d1 = 4'($urandom);
    tick();
    n_cmp++;
    if ({o1, e1, q1} !== 6'b000111) begin
      n_bad++;
      $display("FAIL gap_hold: got %b exp 000111", {o1, e1, q1});
    end
    v1 = 1'b1;
    d1 = 4'd7;
    tick();
    n_cmp++;
    if ({o1, e1, q1} !== 6'b101010) begin
      n_bad++;
      $display("FAIL gap_second: got %b exp 101010", {o1, e1, q1});
    end
    v1 = 1'b0;
    tick();
    n_cmp++;
    if ({o1, e1, q1} !== 6'b001010) begin
      n_bad++;
      $display("FAIL gap_tail: got %b exp 001010", {o1, e1, q1});
    end
  endtask

  task automatic test_multi;
    v4 = 1'b1;
    d4 = 16'h1906;
    tick();
    n_cmp++;
    if ({o4, e4, q4} !== {2'b10, 16'h4C39}) begin
      n_bad++;
      $display("FAIL multi_1906: got %h exp %h", {o4, e4, q4}, {2'b10, 16'h4C39});
    end
    d4 = 16'h12A4;
    tick();
    n_cmp++;
    if ({o4, e4, q4} !== {2'b11, 16'h4507}) begin
      n_bad++;
      $display("FAIL multi_12A4: got %h exp %h", {o4, e4, q4}, {2'b11, 16'h4507});
    end
    v4 = 1'b0;
  endtask

  task automatic test_random;
    logic        ev;
    logic        ee;
    logic [15:0] eq;
    logic [16:0] r;
    ev = o4;
    ee = e4;
    eq = q4;
    for (int k = 0; k < 300; k++) begin
      v4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) d4[4*i +: 4] = 4'($urandom_range(0, 9));
      end else begin
        d4 = 16'($urandom);
      end
      r = ref_conv(d4, 4);
      ev = v4;
      if (v4) begin
        ee = r[16];
        eq = r[15:0];
      end
      tick();
      n_cmp++;
      if ({o4, e4, q4} !== {ev, ee, eq}) begin
        n_bad++;
        $display("FAIL random_%0d: in %h got %h exp %h", k, d4,
                 {o4, e4, q4}, {ev, ee, eq});
      end
    end
    v4 = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [16:0] r;
    v1 = 1'b1;
    d1 = 4'd8;
    v4 = 1'b1;
    d4 = 16'h5A27;
    tick();
    r = ref_conv(16'h5A27, 4);
    n_cmp++;
    if ({o4, e4, q4} !== {1'b1, r}) begin
      n_bad++;
      $display("FAIL pre_arst: got %h exp %h", {o4, e4, q4}, {1'b1, r});
    end
    d1 = 4'd2;
    d4 = 16'h3141;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o1, e1, q1, o4, e4, q4} !== 24'b0) begin
      n_bad++;
      $display("FAIL arst_now: got %h exp 0", {o1, e1, q1, o4, e4, q4});
    end
    tick();
    n_cmp++;
    if ({o1, e1, q1, o4, e4, q4} !== 24'b0) begin
      n_bad++;
      $display("FAIL arst_hold: got %h exp 0", {o1, e1, q1, o4, e4, q4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;
    v4 = 1'b0;
    tick();
    n_cmp++;
    if ({o1, e1, q1, o4, e4, q4} !== 24'b0) begin
      n_bad++;
      $display("FAIL arst_drop: got %h exp 0", {o1, e1, q1, o4, e4, q4});
    end
    v4 = 1'b1;
    d4 = 16'h9870;
    tick();
    n_cmp++;
    if ({o4, e4, q4} !== {2'b10, 16'hCBA3}) begin
      n_bad++;
      $display("FAIL arst_recover: got %h exp %h", {o4, e4, q4}, {2'b10, 16'hCBA3});
    end
    v4 = 1'b0;
  endtask

  initial begin
    v1 = 1'b0;
    d1 = '0;
    v4 = 1'b0;
    d4 = '0;
    test_reset();
    test_sweep();
    test_invalid();
    test_gaps();
    test_multi();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
